// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the mux4 round-robin arbiter.
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Mux select is reversed with respect to the requester index.
  function automatic logic [1:0] owner_to_sel(input logic [1:0] owner);
    return 2'd3 - owner;
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_1.sv
// 2-bit 4:1 data mux: sel 0..3 picks in0..in3.
module mux4_1 (
  input  logic [1:0] in0_i,
  input  logic [1:0] in1_i,
  input  logic [1:0] in2_i,
  input  logic [1:0] in3_i,
  input  logic [1:0] sel_i,
  output logic [1:0] y_o
);

  // Plain select decode.
  always_comb begin
    y_o = in0_i;
    case (sel_i)
      2'b00:   y_o = in0_i;
      2'b01:   y_o = in1_i;
      2'b10:   y_o = in2_i;
      default: y_o = in3_i;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or above start_i, wrapping 3 -> 0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       start_i,
  output logic             found_o,
  output logic [1:0]       winner_o
);

  logic [1:0] idx;

  // Scan the four candidates in rotated order; first hit wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = start_i;
    idx      = start_i;
    for (int k = 0; k < N_REQ; k++) begin
      idx = start_i + 2'(k);
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 2-bit 4:1 mux between four requesters.
// Optional hold-time limit enabled by defining ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [1:0] d0,
  input  logic [1:0] d1,
  input  logic [1:0] d2,
  input  logic [1:0] d3,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [1:0] dout,
  output logic       dout_vld
);

  arb_state_e state_q;
  logic [1:0] owner_q;
  logic [1:0] ptr_q;
  logic [3:0] gnt_q;
  logic [1:0] dout_q;
  logic       dout_vld_q;

  logic [3:0] pick_req;
  logic [1:0] pick_start;
  logic       pick_found;
  logic [1:0] pick_winner;
  logic       owner_req;
  logic       rotate;
  logic       take;
  logic       release_gnt;
  logic [1:0] mux_y;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q;

  assign rotate = (hold_cnt_q == HoldLast);
`else
  logic unused_hold_cfg;

  assign unused_hold_cfg = ^{MAX_HOLD, HOLD_W};
  assign rotate          = 1'b0;
`endif

  // Idle searches all requests from the pointer; busy excludes the owner and searches from owner+1.
  always_comb begin
    owner_req = req[owner_q];
    if (state_q == StIdle) begin
      pick_req   = req;
      pick_start = ptr_q;
    end else begin
      pick_req   = req & ~gnt_q;
      pick_start = owner_q + 2'd1;
    end
  end

  rr_pick4 u_pick (
    .req_i    (pick_req),
    .start_i  (pick_start),
    .found_o  (pick_found),
    .winner_o (pick_winner)
  );

  // Decide between a new grant, dropping to idle, or holding the current owner.
  always_comb begin
    take        = 1'b0;
    release_gnt = 1'b0;
    if (state_q == StIdle) begin
      take = pick_found;
    end else begin
      take        = pick_found && (!owner_req || rotate);
      release_gnt = !owner_req && !pick_found;
    end
  end

  // Arbitration FSM with registered grant, owner and rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
    end else if (take) begin
      state_q <= StBusy;
      owner_q <= pick_winner;
      ptr_q   <= pick_winner + 2'd1;
      gnt_q   <= idx_to_onehot(pick_winner);
    end else if (release_gnt) begin
      state_q <= StIdle;
      ptr_q   <= owner_q + 2'd1;
      gnt_q   <= 4'b0000;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Count cycles the owner keeps the grant; saturate at the limit when nobody else waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (take || release_gnt) begin
      hold_cnt_q <= '0;
    end else if (state_q == StBusy && !rotate) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end
`endif

  assign sel = owner_to_sel(owner_q);

  mux4_1 u_mux (
    .in0_i (d3),
    .in1_i (d2),
    .in2_i (d1),
    .in3_i (d0),
    .sel_i (sel),
    .y_o   (mux_y)
  );

  // Register the selected data; valid follows the grant by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= 2'b00;
      dout_vld_q <= 1'b0;
    end else begin
      dout_q     <= mux_y;
      dout_vld_q <= |gnt_q;
    end
  end

  assign gnt      = gnt_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's 2-bit 4:1 data mux (mux4_1).
- Shares the mux between four requesters: grants one owner at a time, drives the mux select and registers the selected data with a valid flag.
- Sits between four producer blocks and a single 2-bit consumer.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner may keep the grant while others wait (used only with ARB_HOLD_LIMIT_EN); legal range 1..15.
- HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; req[i] belongs to requester i.
- d0  input  2  data of requester 0.
- d1  input  2  data of requester 1.
- d2  input  2  data of requester 2.
- d3  input  2  data of requester 3.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  mux select, driven from the owner register; encoding is requester 3 -> 2'b00, 2 -> 2'b01, 1 -> 2'b10, 0 -> 2'b11 (sel = 3 - owner).
- dout  output  2  registered selected data.
- dout_vld  output  1  dout holds the data of a granted requester.

Behaviour:
- Reset (async, rst_n=0): gnt=4'b0000, sel=2'b11, dout=2'b00, dout_vld=0, state=IDLE, rr pointer=0, hold_cnt=0.
- Reset has immediate effect mid-grant; the first grant after release evaluates from pointer 0.
- States:
  - IDLE: no owner; gnt=0.
  - BUSY: exactly one gnt bit set.
- IDLE -> BUSY: at the edge where any req bit is 1.
  - Winner is the first set req bit searching upward from the rr pointer, wrapping 3 -> 0.
  - gnt and sel update at that edge, giving 1-cycle request-to-grant latency.
- BUSY, owner req still 1 (and no hold-limit rotation): stay; gnt and sel unchanged.
- BUSY, owner req drops to 0 while other requests are pending:
  - At the same edge, grant the next winner, searching from owner+1.
  - No idle bubble.
  - Pointer becomes the new owner + 1.
- BUSY, owner req drops to 0 with no other request: go to IDLE, gnt=0, pointer = old owner + 1 (mod 4).
- Simultaneous requests: resolved purely by the rr pointer; no fixed priority.
- Requests are level-sensitive. A req bit dropping while not owned has no effect.
- Data path:
  - Each cycle, dout <= data selected by the current sel.
  - dout_vld <= |gnt.
  - The first valid dout appears 1 cycle after gnt (2 cycles after req).
- Invariants checked by the bench: gnt is one-hot or zero; sel always matches the gnt bit index per the encoding above.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - hold_cnt increments each BUSY cycle the owner keeps the grant and clears on any owner change.
  - When hold_cnt == MAX_HOLD-1 and any non-owner req is 1, the grant is forcibly rotated at the next edge to the next winner searching from owner+1.
  - If no other requester waits, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- Undefined: no hold_cnt logic; the owner keeps the grant indefinitely while its req is high.

Decomposition:
- Package mux4_arb_pkg:
  - State enum (IDLE, BUSY).
  - Requester-count constant N_REQ=4.
  - Owner-to-sel conversion function (sel = 3 - owner).
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], start index[1:0].
  - Outputs: found, winner index[1:0].
  - Reused for both the idle-grant and handoff paths.
- Data selection instantiates the existing mux4_1 with sel from this block.

Test Plan:
- Reset mid-grant: with requester 2 owning, assert rst_n=0 -> gnt=0, sel=2'b11, dout_vld=0 immediately; after release with req=4'b0001 -> gnt=4'b0001 one edge later.
- Single request: req=4'b0100, d2=2'b10 -> next edge gnt=4'b0100, sel=2'b01; following edge dout=2'b10, dout_vld=1.
- Round-robin fairness: req=4'b1111 held, each owner drops req for 1 cycle after a grant -> grant order 0, 1, 2, 3, 0 with no idle cycle between owners.
- Handoff vs idle: owner 1 releases with req=4'b1000 pending -> gnt=4'b1000 at the same edge. If instead req=0 -> IDLE, gnt=0, dout_vld=0 one cycle later.
- Hold limit (macro on, MAX_HOLD=4): req=4'b0011 held constantly -> gnt alternates 0,0,0,0,1,1,1,1,0. With macro off, gnt stays 4'b0001.
- Data tracking: owner 3 with d3 changing 00 -> 01 -> 11 on successive cycles -> dout follows with 1-cycle delay, sel=2'b00 throughout.
